// File: rtl/id_pkg.sv
// Shared opcode/funct constants and control-flow decode helpers for the ID stage.
package id_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;

  localparam logic [5:0] FUNCT_JR = 6'h08;

  typedef enum logic [2:0] {
    CF_NONE,
    CF_BEQ,
    CF_BNE,
    CF_JUMP,
    CF_JR
  } cf_kind_e;

  function automatic cf_kind_e decode_cf(input logic [31:0] instr);
    cf_kind_e kind;
    kind = CF_NONE;
    case (instr[31:26])
      OP_BEQ:          kind = CF_BEQ;
      OP_BNE:          kind = CF_BNE;
      OP_J, OP_JAL:    kind = CF_JUMP;
      OP_RTYPE:        if (instr[5:0] == FUNCT_JR) kind = CF_JR;
      default:         kind = CF_NONE;
    endcase
    return kind;
  endfunction

  // Logical immediates are zero-extended; everything else sign-extends.
  function automatic logic is_zero_ext(input logic [5:0] op);
    return (op == OP_ANDI) || (op == OP_ORI) || (op == OP_XORI);
  endfunction

endpackage

// File: rtl/regfile.sv
// 32x32 register file with $0 hardwired to zero and write-to-read bypass.
module regfile (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata,
  input  logic [4:0]  raddr1,
  input  logic [4:0]  raddr2,
  output logic [31:0] rdata1,
  output logic [31:0] rdata2
);

  logic [31:0] regs [32];
  logic        write_ok;

  assign write_ok = we && (waddr != 5'd0);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (write_ok) begin
      regs[waddr] <= wdata;
    end
  end

  // A same-cycle writeback is visible to the reader so WB needs no extra stage.
  always_comb begin
    rdata1 = '0;
    rdata2 = '0;
    if (raddr1 != 5'd0) rdata1 = (write_ok && waddr == raddr1) ? wdata : regs[raddr1];
    if (raddr2 != 5'd0) rdata2 = (write_ok && waddr == raddr2) ? wdata : regs[raddr2];
  end

endmodule

// File: rtl/id_stage.sv
// Decode stage: IF/ID register, register file, early branch resolution and hazard detection.
module id_stage
  import id_pkg::*;
#(
  parameter logic [31:0] PC_RESET = 32'h3000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instrF,
  input  logic [31:0] pc_plus4F,
  input  logic        reg_write_w,
  input  logic [4:0]  write_reg_w,
  input  logic [31:0] result_w,
  input  logic        reg_write_e,
  input  logic [4:0]  write_reg_e,
  input  logic        mem_read_e,
  input  logic        reg_write_m,
  input  logic [4:0]  write_reg_m,
  input  logic        mem_read_m,
  input  logic [31:0] alu_out_m,
  output logic        stall,
  output logic        pc_src,
  output logic [31:0] next_pc,
  output logic [31:0] instrD,
  output logic [31:0] pc_plus4D,
  output logic [31:0] rd1D,
  output logic [31:0] rd2D,
  output logic [31:0] imm_extD
);

  logic [4:0]  rs, rt;
  logic [31:0] rf_rd1, rf_rd2;
  logic [31:0] imm_sext, branch_target, jump_target;
  logic        fwd1_m, fwd2_m;
  logic        uses_rs, uses_rt;
  logic        load_use, branch_hazard, taken;
  cf_kind_e    cf;

  assign rs = instrD[25:21];
  assign rt = instrD[20:16];
  assign cf = decode_cf(instrD);

  always_ff @(posedge clk) begin
    if (reset) begin
      instrD    <= '0;
      pc_plus4D <= PC_RESET + 32'd4;
    end else if (stall) begin
      instrD    <= instrD;
      pc_plus4D <= pc_plus4D;
    end else if (pc_src) begin
      instrD    <= '0;
      pc_plus4D <= pc_plus4F;
    end else begin
      instrD    <= instrF;
      pc_plus4D <= pc_plus4F;
    end
  end

  regfile u_regfile (
    .clk    (clk),
    .reset  (reset),
    .we     (reg_write_w),
    .waddr  (write_reg_w),
    .wdata  (result_w),
    .raddr1 (rs),
    .raddr2 (rt),
    .rdata1 (rf_rd1),
    .rdata2 (rf_rd2)
  );

  // MEM-stage ALU results beat the WB bypass because they are younger.
  assign fwd1_m = reg_write_m && !mem_read_m && (write_reg_m != 5'd0) && (write_reg_m == rs);
  assign fwd2_m = reg_write_m && !mem_read_m && (write_reg_m != 5'd0) && (write_reg_m == rt);
  assign rd1D   = fwd1_m ? alu_out_m : rf_rd1;
  assign rd2D   = fwd2_m ? alu_out_m : rf_rd2;

  assign imm_sext = {{16{instrD[15]}}, instrD[15:0]};
  assign imm_extD = is_zero_ext(instrD[31:26]) ? {16'd0, instrD[15:0]} : imm_sext;

  assign branch_target = pc_plus4D + {imm_sext[29:0], 2'b00};
  assign jump_target   = {pc_plus4D[31:28], instrD[25:0], 2'b00};

  assign uses_rs = (cf == CF_BEQ) || (cf == CF_BNE) || (cf == CF_JR);
  assign uses_rt = (cf == CF_BEQ) || (cf == CF_BNE);

  assign load_use = mem_read_e && (write_reg_e != 5'd0) &&
                    ((write_reg_e == rs) || (write_reg_e == rt));

  // Branch operands are compared in ID, so any result not yet forwardable must wait.
  always_comb begin
    branch_hazard = 1'b0;
    if (uses_rs && rs != 5'd0) begin
      if (reg_write_e && write_reg_e == rs) branch_hazard = 1'b1;
      if (mem_read_m  && write_reg_m == rs) branch_hazard = 1'b1;
    end
    if (uses_rt && rt != 5'd0) begin
      if (reg_write_e && write_reg_e == rt) branch_hazard = 1'b1;
      if (mem_read_m  && write_reg_m == rt) branch_hazard = 1'b1;
    end
  end

  assign stall = load_use || branch_hazard;

  always_comb begin
    taken   = 1'b0;
    next_pc = pc_plus4D;
    case (cf)
      CF_BEQ: begin
        taken   = (rd1D == rd2D);
        next_pc = branch_target;
      end
      CF_BNE: begin
        taken   = (rd1D != rd2D);
        next_pc = branch_target;
      end
      CF_JUMP: begin
        taken   = 1'b1;
        next_pc = jump_target;
      end
      CF_JR: begin
        taken   = 1'b1;
        next_pc = rd1D;
      end
      default: begin
        taken   = 1'b0;
        next_pc = pc_plus4D;
      end
    endcase
  end

  assign pc_src = taken && !stall;

endmodule

// File: tb/tb_id_stage.sv
// Scoreboard-driven bench for id_stage: expectations are queued with each stimulus and drained at the falling edge.
`timescale 1ns/1ps
module tb_id_stage;

  localparam logic [31:0] BEQ_5_6   = 32'h10A6_0003;
  localparam logic [31:0] BNE_5_6   = 32'h14A6_0003;
  localparam logic [31:0] BEQ_NEG   = 32'h1000_FFFF;
  localparam logic [31:0] J_C10     = 32'h0800_0C10;
  localparam logic [31:0] ADDI_2    = 32'h2002_0005;
  localparam logic [31:0] ADD_8_9   = 32'h0109_5020;
  localparam logic [31:0] ADD_9_9   = 32'h0129_5820;
  localparam logic [31:0] ADD_5_6   = 32'h00A6_0820;
  localparam logic [31:0] JR_31     = 32'h03E0_0008;
  localparam logic [31:0] ORI_8000  = 32'h3401_8000;
  localparam logic [31:0] ADDI_8000 = 32'h2001_8000;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instrF, pc_plus4F;
  logic        reg_write_w;
  logic [4:0]  write_reg_w;
  logic [31:0] result_w;
  logic        reg_write_e;
  logic [4:0]  write_reg_e;
  logic        mem_read_e;
  logic        reg_write_m;
  logic [4:0]  write_reg_m;
  logic        mem_read_m;
  logic [31:0] alu_out_m;
  logic        stall, pc_src;
  logic [31:0] next_pc, instrD, pc_plus4D, rd1D, rd2D, imm_extD;

  typedef enum {S_STALL, S_PCSRC, S_NEXTPC, S_INSTRD, S_PC4D, S_RD1, S_RD2, S_IMM} sig_e;
  typedef struct {
    sig_e        sig;
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  id_stage #(.PC_RESET(32'h3000)) dut (
    .clk         (clk),
    .reset       (reset),
    .instrF      (instrF),
    .pc_plus4F   (pc_plus4F),
    .reg_write_w (reg_write_w),
    .write_reg_w (write_reg_w),
    .result_w    (result_w),
    .reg_write_e (reg_write_e),
    .write_reg_e (write_reg_e),
    .mem_read_e  (mem_read_e),
    .reg_write_m (reg_write_m),
    .write_reg_m (write_reg_m),
    .mem_read_m  (mem_read_m),
    .alu_out_m   (alu_out_m),
    .stall       (stall),
    .pc_src      (pc_src),
    .next_pc     (next_pc),
    .instrD      (instrD),
    .pc_plus4D   (pc_plus4D),
    .rd1D        (rd1D),
    .rd2D        (rd2D),
    .imm_extD    (imm_extD)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] observe(sig_e s);
    case (s)
      S_STALL:  return {31'd0, stall};
      S_PCSRC:  return {31'd0, pc_src};
      S_NEXTPC: return next_pc;
      S_INSTRD: return instrD;
      S_PC4D:   return pc_plus4D;
      S_RD1:    return rd1D;
      S_RD2:    return rd2D;
      default:  return imm_extD;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    end
  endtask

  task automatic expectOut(input sig_e s, input string tag, input logic [31:0] v);
    exp_t e;
    e.sig = s;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic drainScoreboard();
    exp_t e;
    @(negedge clk);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      checkOutput(e.tag, observe(e.sig), e.val);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [31:0] instr, input logic [31:0] pc4);
    instrF    = instr;
    pc_plus4F = pc4;
  endtask

  task automatic clearPipe();
    reg_write_w = 1'b0; write_reg_w = '0; result_w  = '0;
    reg_write_e = 1'b0; write_reg_e = '0; mem_read_e = 1'b0;
    reg_write_m = 1'b0; write_reg_m = '0; mem_read_m = 1'b0;
    alu_out_m   = '0;
  endtask

  task automatic writeReg(input logic [4:0] idx, input logic [31:0] val);
    reg_write_w = 1'b1;
    write_reg_w = idx;
    result_w    = val;
    step();
    reg_write_w = 1'b0;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b1;
    clearPipe();
    applyStimulus('0, '0);
    step(); step();
    expectOut(S_INSTRD, "rst_instrD", 32'h0);
    expectOut(S_PC4D,   "rst_pc4D",   32'h3004);
    expectOut(S_STALL,  "rst_stall",  32'h0);
    drainScoreboard();
    reset = 1'b0;
    step();

    // taken beq, then the wrong-path fetch is flushed
    writeReg(5'd5, 32'd7);
    writeReg(5'd6, 32'd7);
    applyStimulus(BEQ_5_6, 32'h3008);
    step();
    applyStimulus(ADDI_2, 32'h300C);
    expectOut(S_INSTRD, "beq_instrD", BEQ_5_6);
    expectOut(S_RD1,    "beq_rd1",    32'd7);
    expectOut(S_RD2,    "beq_rd2",    32'd7);
    expectOut(S_PCSRC,  "beq_pcsrc",  32'd1);
    expectOut(S_NEXTPC, "beq_target", 32'h3014);
    drainScoreboard();
    step();
    applyStimulus(BNE_5_6, 32'h3010);
    expectOut(S_INSTRD, "flush_instrD", 32'h0);
    expectOut(S_PC4D,   "flush_pc4D",   32'h300C);
    drainScoreboard();
    step();
    applyStimulus('0, 32'h3014);
    expectOut(S_INSTRD, "bne_instrD", BNE_5_6);
    expectOut(S_PCSRC,  "bne_not_taken", 32'd0);
    drainScoreboard();
    step();

    // backward branch wraps below zero
    applyStimulus(BEQ_NEG, 32'h0);
    step();
    applyStimulus('0, 32'h4);
    expectOut(S_NEXTPC, "beq_wrap_target", 32'hFFFF_FFFC);
    expectOut(S_PCSRC,  "beq_wrap_pcsrc",  32'd1);
    drainScoreboard();
    step();

    // j keeps the upper nibble of pc_plus4D
    applyStimulus(J_C10, 32'hA000_3000);
    step();
    applyStimulus('0, 32'h0);
    expectOut(S_NEXTPC, "j_target", 32'hA000_3040);
    expectOut(S_PCSRC,  "j_pcsrc",  32'd1);
    drainScoreboard();
    step();

    // load-use stall holds IF/ID for one cycle
    applyStimulus(ADD_8_9, 32'h3020);
    step();
    mem_read_e  = 1'b1; reg_write_e = 1'b1; write_reg_e = 5'd8;
    applyStimulus(ADD_9_9, 32'h3024);
    expectOut(S_STALL, "lu_stall", 32'd1);
    expectOut(S_PCSRC, "lu_pcsrc", 32'd0);
    drainScoreboard();
    step();
    clearPipe();
    expectOut(S_INSTRD, "lu_hold_instr", ADD_8_9);
    expectOut(S_PC4D,   "lu_hold_pc4",   32'h3020);
    expectOut(S_STALL,  "lu_released",   32'd0);
    drainScoreboard();
    step();
    expectOut(S_INSTRD, "lu_next_instr", ADD_9_9);
    expectOut(S_PC4D,   "lu_next_pc4",   32'h3024);
    drainScoreboard();

    // writeback bypass and the $0 sink
    reg_write_w = 1'b1; write_reg_w = 5'd9; result_w = 32'h1234;
    expectOut(S_RD1, "wb_bypass_rd1", 32'h1234);
    expectOut(S_RD2, "wb_bypass_rd2", 32'h1234);
    drainScoreboard();
    step();
    reg_write_w = 1'b0;
    applyStimulus('0, 32'h3028);
    expectOut(S_RD1, "rf_stored_rd1", 32'h1234);
    drainScoreboard();
    step();
    reg_write_w = 1'b1; write_reg_w = 5'd0; result_w = 32'hDEAD_BEEF;
    expectOut(S_RD1, "r0_bypass", 32'h0);
    drainScoreboard();
    step();
    reg_write_w = 1'b0;
    expectOut(S_RD1, "r0_stored", 32'h0);
    drainScoreboard();

    // jr: hazards stall first, then MEM forwarding supplies the target
    applyStimulus(JR_31, 32'h3030);
    step();
    applyStimulus('0, 32'h3034);
    reg_write_m = 1'b1; write_reg_m = 5'd31; mem_read_m = 1'b1;
    expectOut(S_STALL, "jr_mload_stall", 32'd1);
    expectOut(S_PCSRC, "jr_mload_pcsrc", 32'd0);
    drainScoreboard();
    step();
    reg_write_m = 1'b0; mem_read_m = 1'b0;
    reg_write_e = 1'b1; write_reg_e = 5'd31;
    expectOut(S_STALL,  "jr_ex_stall", 32'd1);
    expectOut(S_INSTRD, "jr_held",     JR_31);
    drainScoreboard();
    step();
    clearPipe();
    reg_write_m = 1'b1; write_reg_m = 5'd31; alu_out_m = 32'h3040;
    reg_write_w = 1'b1; write_reg_w = 5'd31; result_w  = 32'h5555;
    expectOut(S_STALL,  "jr_fwd_stall",  32'd0);
    expectOut(S_RD1,    "jr_fwd_rd1",    32'h3040);
    expectOut(S_NEXTPC, "jr_fwd_target", 32'h3040);
    expectOut(S_PCSRC,  "jr_fwd_pcsrc",  32'd1);
    drainScoreboard();
    step();
    clearPipe();

    // immediate extension
    applyStimulus(ORI_8000, 32'h3040);
    step();
    applyStimulus(ADDI_8000, 32'h3044);
    expectOut(S_IMM, "ori_zext", 32'h0000_8000);
    drainScoreboard();
    step();
    expectOut(S_IMM, "addi_sext", 32'hFFFF_8000);
    drainScoreboard();

    // reset during a stall wins and clears the register file
    applyStimulus(ADD_8_9, 32'h3050);
    step();
    mem_read_e = 1'b1; reg_write_e = 1'b1; write_reg_e = 5'd8;
    expectOut(S_STALL, "pre_rst_stall", 32'd1);
    drainScoreboard();
    reset = 1'b1;
    step();
    clearPipe();
    expectOut(S_INSTRD, "rst_stall_instrD", 32'h0);
    expectOut(S_PC4D,   "rst_stall_pc4D",   32'h3004);
    drainScoreboard();
    reset = 1'b0;
    applyStimulus(ADD_5_6, 32'h3008);
    step();
    applyStimulus(ADD_9_9, 32'h300C);
    expectOut(S_RD1, "rst_r5", 32'h0);
    expectOut(S_RD2, "rst_r6", 32'h0);
    drainScoreboard();
    step();
    applyStimulus(JR_31, 32'h3010);
    expectOut(S_RD1, "rst_r9", 32'h0);
    drainScoreboard();
    step();
    expectOut(S_RD1, "rst_r31", 32'h0);
    drainScoreboard();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
